// File: rtl/memory_master_pkg.sv
// Shared types and defaults for the RAM initiator-side controller.
package memory_master_pkg;

  localparam int DEFAULT_D_WIDTH = 16;
  localparam int DEFAULT_A_WIDTH = 12;
  localparam int DEFAULT_C_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, READ, HOLD, WRITE} memory_master_state_t;

endpackage

// File: rtl/memory_master.sv
// Initiator for the word-addressed RAM: single-word writes and burst reads
// from a valid/ready request port, read words returned on a valid/ready stream.
module memory_master
  import memory_master_pkg::*;
#(
  parameter int D_WIDTH = DEFAULT_D_WIDTH,
  parameter int A_WIDTH = DEFAULT_A_WIDTH,
  parameter int C_WIDTH = DEFAULT_C_WIDTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid_in,
  output logic               req_ready_out,
  input  logic               req_write_in,
  input  logic [A_WIDTH-1:0] req_address_in,
  input  logic [D_WIDTH-1:0] req_data_in,
  input  logic [C_WIDTH-1:0] req_count_in,
  output logic               resp_valid_out,
  input  logic               resp_ready_in,
  output logic [D_WIDTH-1:0] resp_data_out,
  output logic               write_done_out,
  output logic [A_WIDTH-1:0] mem_address_out,
  output logic [D_WIDTH-1:0] mem_data_out,
  input  logic [D_WIDTH-1:0] mem_data_in,
  output logic               mem_read_enable_out,
  output logic               mem_write_enable_out
);

  memory_master_state_t state_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   data_q;
  logic [C_WIDTH-1:0]   remaining_q;
  logic [D_WIDTH-1:0]   resp_data_q;
  logic                 resp_valid_q;
  logic                 write_done_q;

  logic [A_WIDTH-1:0]   addr_d;
  logic [C_WIDTH-1:0]   remaining_d;

  // Natural-width increment gives the 0xFFF -> 0x000 wrap for free.
  assign addr_d      = addr_q + A_WIDTH'(1);
  assign remaining_d = remaining_q - C_WIDTH'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      remaining_q  <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      write_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_in) begin
            addr_q      <= req_address_in;
            data_q      <= req_data_in;
            remaining_q <= req_count_in;
            state_q     <= req_write_in ? WRITE : READ;
          end
        end
        WRITE: begin
          write_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        READ: begin
          resp_data_q  <= mem_data_in;
          resp_valid_q <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (resp_valid_q && resp_ready_in) begin
            resp_valid_q <= 1'b0;
            if (remaining_q == '0) begin
              state_q <= IDLE;
            end else begin
              addr_q      <= addr_d;
              remaining_q <= remaining_d;
              state_q     <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Enables decode from state only so reset drops them without a clock edge.
  assign req_ready_out        = (state_q == IDLE);
  assign mem_read_enable_out  = (state_q == READ);
  assign mem_write_enable_out = (state_q == WRITE);
  assign mem_address_out      = addr_q;
  assign mem_data_out         = data_q;
  assign resp_valid_out       = resp_valid_q;
  assign resp_data_out        = resp_data_q;
  assign write_done_out       = write_done_q;

endmodule

// File: tb/tb_memory_master.sv
// Randomised bench for memory_master: a bench-side RAM, a transaction-level
// reference model with a per-cycle compare process, and directed pinning tests.
module tb_memory_master;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic          req_write_in = 1'b0;
  logic [AW-1:0] req_address_in = '0;
  logic [DW-1:0] req_data_in = '0;
  logic [CW-1:0] req_count_in = '0;
  logic          resp_valid_out;
  logic          resp_ready_in = 1'b0;
  logic [DW-1:0] resp_data_out;
  logic          write_done_out;
  logic [AW-1:0] mem_address_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic          mem_read_enable_out;
  logic          mem_write_enable_out;

  memory_master #(.D_WIDTH(DW), .A_WIDTH(AW), .C_WIDTH(CW)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .req_valid_in        (req_valid_in),
    .req_ready_out       (req_ready_out),
    .req_write_in        (req_write_in),
    .req_address_in      (req_address_in),
    .req_data_in         (req_data_in),
    .req_count_in        (req_count_in),
    .resp_valid_out      (resp_valid_out),
    .resp_ready_in       (resp_ready_in),
    .resp_data_out       (resp_data_out),
    .write_done_out      (write_done_out),
    .mem_address_out     (mem_address_out),
    .mem_data_out        (mem_data_out),
    .mem_data_in         (mem_data_in),
    .mem_read_enable_out (mem_read_enable_out),
    .mem_write_enable_out(mem_write_enable_out)
  );

  always #5 clock = ~clock;

  // Bench RAM: transparent read while enabled, write commits on the edge.
  logic [DW-1:0] ram [0:DEPTH-1] = '{default: '0};
  always @(posedge clock) begin
    if (mem_write_enable_out) ram[mem_address_out] <= mem_data_out;
  end
  assign mem_data_in = mem_read_enable_out ? ram[mem_address_out] : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] model_mem [0:DEPTH-1] = '{default: '0};
  logic [AW-1:0] exp_raddr_q[$];
  logic [DW-1:0] exp_rdata_q[$];
  logic [AW-1:0] exp_waddr_q[$];
  logic [DW-1:0] exp_wdata_q[$];
  int            pend_stage = 0;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic          prev_we = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_resp = '0;
  int            hs_count = 0;
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] data_log[$];
  int            rdy_mode = 2;  // 0 random, 1 stall, 2 always ready

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       resp_ready_in = ($urandom_range(0, 2) != 0);
      1:       resp_ready_in = 1'b0;
      default: resp_ready_in = 1'b1;
    endcase
  end

  // Compare process: outputs sampled mid-cycle, inputs are stable for the next edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_raddr_q.delete(); exp_rdata_q.delete();
      exp_waddr_q.delete(); exp_wdata_q.delete();
      pend_stage = 0;
      prev_we = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (pend_stage == 2) begin
        model_mem[pend_a] = pend_d;
        pend_stage = 0;
      end else if (pend_stage == 1) begin
        pend_stage = 2;
      end
      chk("write_done_pulse", 32'(write_done_out), 32'(prev_we));
      chk("enables_exclusive", 32'(mem_read_enable_out & mem_write_enable_out), 32'd0);
      if (mem_write_enable_out) begin
        chk("write_expected", 32'(exp_waddr_q.size() != 0), 32'd1);
        if (exp_waddr_q.size() != 0) begin
          chk("write_addr", 32'(mem_address_out), 32'(exp_waddr_q.pop_front()));
          chk("write_data", 32'(mem_data_out), 32'(exp_wdata_q.pop_front()));
        end
        chk("ready_in_write", 32'(req_ready_out), 32'd0);
      end
      if (mem_read_enable_out) begin
        addr_log.push_back(mem_address_out);
        chk("read_expected", 32'(exp_raddr_q.size() != 0), 32'd1);
        if (exp_raddr_q.size() != 0)
          chk("read_addr", 32'(mem_address_out), 32'(exp_raddr_q.pop_front()));
        chk("ready_in_read", 32'(req_ready_out), 32'd0);
      end
      if (prev_hold) begin
        chk("resp_valid_held", 32'(resp_valid_out), 32'd1);
        chk("resp_data_stable", 32'(resp_data_out), 32'(prev_resp));
      end
      if (resp_valid_out) begin
        chk("ready_in_hold", 32'(req_ready_out), 32'd0);
        if (resp_ready_in) begin
          chk("resp_expected", 32'(exp_rdata_q.size() != 0), 32'd1);
          if (exp_rdata_q.size() != 0)
            chk("resp_data", 32'(resp_data_out), 32'(exp_rdata_q.pop_front()));
          data_log.push_back(resp_data_out);
          hs_count++;
        end
      end
      prev_hold = resp_valid_out && !resp_ready_in;
      prev_resp = resp_data_out;
      prev_we   = mem_write_enable_out;
      if (req_valid_in && req_ready_out) begin
        if (req_write_in) begin
          exp_waddr_q.push_back(req_address_in);
          exp_wdata_q.push_back(req_data_in);
          pend_a = req_address_in;
          pend_d = req_data_in;
          pend_stage = 1;
        end else begin
          for (int i = 0; i <= int'(req_count_in); i++) begin
            logic [AW-1:0] a;
            a = req_address_in + AW'(i);
            exp_raddr_q.push_back(a);
            exp_rdata_q.push_back(model_mem[a]);
          end
        end
      end
    end
  end

  // Holds the request until accepted; returns 1 time unit after the accept edge.
  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [CW-1:0] c);
    int n = 0;
    @(posedge clock); #1;
    req_valid_in = 1'b1; req_write_in = w; req_address_in = a;
    req_data_in = d; req_count_in = c;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready_out && n < 500);
    chk("accept_timeout", 32'(req_ready_out), 32'd1);
    @(posedge clock); #1;
    req_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(req_ready_out && !resp_valid_out && exp_rdata_q.size() == 0 &&
                 exp_waddr_q.size() == 0 && pend_stage == 0) && n < 1000);
    chk("idle_timeout", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, n, my_cyc, last_hs;
    logic [AW-1:0] wrap_a [4];
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    wrap_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready_out), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_out), 32'd0);
    chk("rst_write_done", 32'(write_done_out), 32'd0);
    chk("rst_re", 32'(mem_read_enable_out), 32'd0);
    chk("rst_we", 32'(mem_write_enable_out), 32'd0);
    chk("rst_addr", 32'(mem_address_out), 32'd0);
    chk("rst_resp_data", 32'(resp_data_out), 32'd0);
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;

    // Directed write 0x005 <= 0x1234
    send_req(1'b1, 12'h005, 16'h1234, 4'd0);
    @(negedge clock);
    chk("wr_we", 32'(mem_write_enable_out), 32'd1);
    chk("wr_addr", 32'(mem_address_out), 32'h005);
    chk("wr_data", 32'(mem_data_out), 32'h1234);
    chk("wr_ready_busy", 32'(req_ready_out), 32'd0);
    @(negedge clock);
    chk("wr_we_one_cycle", 32'(mem_write_enable_out), 32'd0);
    chk("wr_done", 32'(write_done_out), 32'd1);
    chk("wr_ready_back", 32'(req_ready_out), 32'd1);
    chk("wr_ram", 32'(ram[12'h005]), 32'h1234);
    @(negedge clock);
    chk("wr_done_one_cycle", 32'(write_done_out), 32'd0);

    // Directed single read of 0x005
    rdy_mode = 2;
    send_req(1'b0, 12'h005, 16'h0000, 4'd0);
    @(negedge clock);
    chk("rd_re", 32'(mem_read_enable_out), 32'd1);
    chk("rd_addr", 32'(mem_address_out), 32'h005);
    chk("rd_valid_early", 32'(resp_valid_out), 32'd0);
    @(negedge clock);
    chk("rd_valid", 32'(resp_valid_out), 32'd1);
    chk("rd_data", 32'(resp_data_out), 32'h1234);
    chk("rd_re_hold", 32'(mem_read_enable_out), 32'd0);
    @(negedge clock);
    chk("rd_valid_drop", 32'(resp_valid_out), 32'd0);
    chk("rd_idle", 32'(req_ready_out), 32'd1);

    // Wrap-around burst
    for (int i = 0; i < 4; i++) send_req(1'b1, wrap_a[i], 16'(16'hA0 + i), 4'd0);
    wait_idle();
    addr_log.delete(); data_log.delete();
    hs0 = hs_count;
    rdy_mode = 0;
    send_req(1'b0, 12'hFFE, 16'h0000, 4'd3);
    wait_idle();
    chk("wrap_handshakes", 32'(hs_count - hs0), 32'd4);
    chk("wrap_addr_count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_a[i]));
      chk("wrap_data", 32'(data_log[i]), 32'h00A0 + 32'(i));
    end

    // Backpressure mid-burst
    send_req(1'b1, 12'h0F0, 16'h0C01, 4'd0);
    send_req(1'b1, 12'h0F1, 16'h0C02, 4'd0);
    send_req(1'b1, 12'h0F2, 16'h0C03, 4'd0);
    wait_idle();
    rdy_mode = 2;
    data_log.delete();
    hs0 = hs_count;
    send_req(1'b0, 12'h0F0, 16'h0000, 4'd2);
    n = 0;
    while (hs_count == hs0 && n < 100) begin @(negedge clock); n++; end
    rdy_mode = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!resp_valid_out && n < 100);
    chk("bp_valid_seen", 32'(resp_valid_out), 32'd1);
    hold_data = resp_data_out;
    hold_addr = mem_address_out;
    repeat (5) begin
      @(negedge clock);
      chk("bp_data_stable", 32'(resp_data_out), 32'(hold_data));
      chk("bp_re_low", 32'(mem_read_enable_out), 32'd0);
      chk("bp_addr_hold", 32'(mem_address_out), 32'(hold_addr));
    end
    rdy_mode = 2;
    wait_idle();
    chk("bp_handshakes", 32'(hs_count - hs0), 32'd3);
    chk("bp_word_count", 32'(data_log.size()), 32'd3);
    if (data_log.size() == 3) begin
      chk("bp_word0", 32'(data_log[0]), 32'h0C01);
      chk("bp_word1", 32'(data_log[1]), 32'h0C02);
      chk("bp_word2", 32'(data_log[2]), 32'h0C03);
    end

    // Request held during a burst is taken on the first IDLE edge
    rdy_mode = 0;
    send_req(1'b0, 12'h0F0, 16'h0000, 4'd2);
    req_valid_in = 1'b1; req_write_in = 1'b1;
    req_address_in = 12'h0F8; req_data_in = 16'h5A5A; req_count_in = 4'd0;
    my_cyc = 0; last_hs = -10;
    do begin
      @(negedge clock);
      my_cyc++;
      if (resp_valid_out && resp_ready_in) last_hs = my_cyc;
    end while (!req_ready_out && my_cyc < 300);
    chk("blk_accepted", 32'(req_ready_out), 32'd1);
    chk("blk_accept_gap", 32'(my_cyc - last_hs), 32'd1);
    @(posedge clock); #1;
    req_valid_in = 1'b0;
    wait_idle();
    chk("blk_ram", 32'(ram[12'h0F8]), 32'h5A5A);

    // Reset abort during WRITE
    rdy_mode = 2;
    send_req(1'b1, 12'h0AA, 16'h1111, 4'd0);
    wait_idle();
    send_req(1'b1, 12'h0AA, 16'hBEEF, 4'd0);
    @(negedge clock);
    chk("abort_we_before", 32'(mem_write_enable_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_we_drop", 32'(mem_write_enable_out), 32'd0);
    chk("abort_re", 32'(mem_read_enable_out), 32'd0);
    chk("abort_idle", 32'(req_ready_out), 32'd1);
    chk("abort_addr", 32'(mem_address_out), 32'd0);
    chk("abort_data", 32'(mem_data_out), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid_out), 32'd0);
    @(posedge clock); #1;
    chk("abort_ram_kept", 32'(ram[12'h0AA]), 32'h1111);
    @(negedge clock);
    @(posedge clock); #3;
    reset_n = 1'b1;
    data_log.delete();
    send_req(1'b0, 12'h0AA, 16'h0000, 4'd0);
    wait_idle();
    chk("abort_readback", 32'(data_log.size() == 1 ? data_log[0] : 16'hFFFF), 32'h1111);

    // Randomised traffic
    for (int t = 0; t < 60; t++) begin
      logic w;
      logic [AW-1:0] a;
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(12'h0E0, 12'h0FF))
                                      : AW'($urandom_range(12'hFF8, 12'hFFF));
      rdy_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      send_req(w, a, 16'($urandom), 4'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
